pe_hi_scan: RTL and testbench



---
 rtl/pe_pkg.sv | 29 ++
 rtl/pe_prio_enc.sv | 31 +++
 rtl/pe_hi_scan.sv | 117 +++++++++++
 tb/tb_pe_hi_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and helpers for the priority-encoder scan family.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Scanner FSM encoding (one bit, explicit width)
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Ceiling log2 that never returns less than 1, so a one-entry range still
    // gets a real (one-bit) counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pe_prio_enc
// Description : Combinational highest-bit priority encoder of arbitrary width.
//               idx is the position of the highest set bit (0 if none),
//               any flags a non-zero vector.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: later (higher) set bits overwrite lower ones
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule : pe_prio_enc
`default_nettype wire

// File: rtl/pe_hi_scan.sv
`default_nettype none
// ============================================================================
// Module      : pe_hi_scan
// Description : Accepts a WIDTH-bit vector over valid/ready and streams out
//               the positions of its set bits, highest first, up to MAX_HITS
//               beats. A zero vector yields one beat flagged empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_hi_scan
    import pe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HITS = WIDTH,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int RANK_W   = clog2_min1(MAX_HITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [RANK_W-1:0] out_rank,
    output logic              out_last,
    output logic              out_empty
);

    state_t              state, state_nxt;
    logic [WIDTH-1:0]    held, held_nxt;
    logic [RANK_W-1:0]   rank, rank_nxt;

    logic [IDX_W-1:0]    enc_idx;
    logic                enc_any;
    logic                single_bit;
    logic                rank_full;
    logic [WIDTH-1:0]    clr_mask;
    logic                beat_last;

    pe_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec (held),
        .idx (enc_idx),
        .any (enc_any)
    );

    // At most one bit set (also true for zero) means this beat ends the vector
    assign single_bit = ((held & (held - WIDTH'(1))) == '0);
    assign rank_full  = (rank == RANK_W'(MAX_HITS - 1));
    assign clr_mask   = WIDTH'(1) << enc_idx;
    assign beat_last  = !enc_any || single_bit || rank_full;

    // State, held vector and rank counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            held  <= '0;
            rank  <= '0;
        end else begin
            state <= state_nxt;
            held  <= held_nxt;
            rank  <= rank_nxt;
        end
    end

    // Next-state logic and handshake/beat outputs; beat fields are forced to
    // zero outside SCAN so the idle bus matches the reset values.
    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        rank_nxt  = rank;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_idx   = '0;
        out_rank  = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_SCAN;
                    held_nxt  = in_data;
                    rank_nxt  = '0;
                end
            end
            ST_SCAN: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_idx   = enc_idx;
                out_rank  = rank;
                out_last  = beat_last;
                out_empty = !enc_any;
                if (out_ready) begin
                    if (beat_last) begin
                        // Any bits beyond MAX_HITS are dropped here
                        state_nxt = ST_IDLE;
                        held_nxt  = '0;
                        rank_nxt  = '0;
                    end else begin
                        held_nxt  = held & ~clr_mask;
                        rank_nxt  = rank + RANK_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                held_nxt  = '0;
                rank_nxt  = '0;
            end
        endcase
    end

endmodule : pe_hi_scan
`default_nettype wire

// File: tb/tb_pe_hi_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_hi_scan
// Description : Directed, table-driven bench for pe_hi_scan over three
//               configurations (8/8, 8/2, 16/16) plus an async-reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_hi_scan;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Instance A: WIDTH=8, MAX_HITS=8
    logic       a_iv, a_ir, a_ov, a_or, a_last, a_empty;
    logic [7:0] a_d;
    logic [2:0] a_idx, a_rank;
    // Instance B: WIDTH=8, MAX_HITS=2
    logic       b_iv, b_ir, b_ov, b_or, b_last, b_empty;
    logic [7:0] b_d;
    logic [2:0] b_idx;
    logic [0:0] b_rank;
    // Instance C: WIDTH=16, MAX_HITS=16
    logic        c_iv, c_ir, c_ov, c_or, c_last, c_empty;
    logic [15:0] c_d;
    logic [3:0]  c_idx, c_rank;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_hi_scan #(.WIDTH(8), .MAX_HITS(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_idx(a_idx), .out_rank(a_rank),
        .out_last(a_last), .out_empty(a_empty));

    pe_hi_scan #(.WIDTH(8), .MAX_HITS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_idx(b_idx), .out_rank(b_rank),
        .out_last(b_last), .out_empty(b_empty));

    pe_hi_scan #(.WIDTH(16), .MAX_HITS(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_d),
        .out_valid(c_ov), .out_ready(c_or), .out_idx(c_idx), .out_rank(c_rank),
        .out_last(c_last), .out_empty(c_empty));

    // Packed expectation: {out_valid, in_ready, idx[7:0], rank[7:0], last, empty}
    typedef struct {
        int          dut;
        string       name;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [19:0] e(logic ov, logic ir, int idx, int rank, logic last, logic empty);
        return {ov, ir, 8'(idx), 8'(rank), last, empty};
    endfunction

    function automatic vec_t mk(int dut, string name, logic iv, logic [15:0] d, logic ordy, logic [19:0] exp);
        vec_t v;
        v.dut = dut; v.name = name; v.iv = iv; v.d = d; v.ordy = ordy; v.exp = exp;
        return v;
    endfunction

    // Drive the selected instance; the others sit idle with out_ready high
    task automatic set_in(int dut, logic iv, logic [15:0] d, logic ordy);
        a_iv = 1'b0; a_d = '0; a_or = 1'b1;
        b_iv = 1'b0; b_d = '0; b_or = 1'b1;
        c_iv = 1'b0; c_d = '0; c_or = 1'b1;
        case (dut)
            0: begin a_iv = iv; a_d = d[7:0]; a_or = ordy; end
            1: begin b_iv = iv; b_d = d[7:0]; b_or = ordy; end
            default: begin c_iv = iv; c_d = d; c_or = ordy; end
        endcase
    endtask

    function automatic logic [19:0] get_out(int dut);
        case (dut)
            0: return {a_ov, a_ir, 8'(a_idx), 8'(a_rank), a_last, a_empty};
            1: return {b_ov, b_ir, 8'(b_idx), 8'(b_rank), b_last, b_empty};
            default: return {c_ov, c_ir, 8'(c_idx), 8'(c_rank), c_last, c_empty};
        endcase
    endfunction

    task automatic check(int dut, string name, logic [19:0] exp);
        logic [19:0] got;
        got = get_out(dut);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got v=%b rdy=%b idx=%0d rank=%0d last=%b empty=%b, want v=%b rdy=%b idx=%0d rank=%0d last=%b empty=%b",
                     name, dut, got[19], got[18], got[17:10], got[9:2], got[1], got[0],
                     exp[19], exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [19:0] idle;
        idle = e(0, 1, 0, 0, 0, 0);

        // Test 1: 0xA5 on 8/8 -> 7,5,2,0
        tbl.push_back(mk(0, "a5_accept", 1, 16'h00A5, 1, idle));
        tbl.push_back(mk(0, "a5_b0",     0, 16'h0000, 1, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(0, "a5_b1",     0, 16'h0000, 1, e(1, 0, 5, 1, 0, 0)));
        tbl.push_back(mk(0, "a5_b2",     0, 16'h0000, 1, e(1, 0, 2, 2, 0, 0)));
        tbl.push_back(mk(0, "a5_b3",     0, 16'h0000, 1, e(1, 0, 0, 3, 1, 0)));
        // Test 2: empty vector
        tbl.push_back(mk(0, "a5_idle",   1, 16'h0000, 1, idle));
        tbl.push_back(mk(0, "zero_beat", 0, 16'h0000, 1, e(1, 0, 0, 0, 1, 1)));
        // Test 3: 0x81 with backpressure and an ignored in_valid pulse
        tbl.push_back(mk(0, "zero_idle", 1, 16'h0081, 0, idle));
        tbl.push_back(mk(0, "bp_hold0",  0, 16'h0000, 0, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(0, "bp_hold1",  1, 16'h00FF, 0, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(0, "bp_hold2",  1, 16'h00FF, 0, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(0, "bp_hold3",  0, 16'h0000, 1, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(0, "bp_last",   0, 16'h0000, 1, e(1, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, "bp_idle",   0, 16'h0000, 1, idle));
        // Test 4: MAX_HITS=2 truncation of 0xFF, then 0x10
        tbl.push_back(mk(1, "ff_accept", 1, 16'h00FF, 1, idle));
        tbl.push_back(mk(1, "ff_b0",     0, 16'h0000, 1, e(1, 0, 7, 0, 0, 0)));
        tbl.push_back(mk(1, "ff_b1",     0, 16'h0000, 1, e(1, 0, 6, 1, 1, 0)));
        tbl.push_back(mk(1, "ff_idle",   1, 16'h0010, 1, idle));
        tbl.push_back(mk(1, "x10_b0",    0, 16'h0000, 1, e(1, 0, 4, 0, 1, 0)));
        tbl.push_back(mk(1, "x10_idle",  0, 16'h0000, 1, idle));
        // Test 6: back-to-back on 16/16 with in_valid held
        tbl.push_back(mk(2, "b2b_acc0",  1, 16'h0003, 1, idle));
        tbl.push_back(mk(2, "b2b_b0",    1, 16'h4000, 1, e(1, 0, 1, 0, 0, 0)));
        tbl.push_back(mk(2, "b2b_b1",    1, 16'h4000, 1, e(1, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(2, "b2b_gap",   1, 16'h4000, 1, idle));
        tbl.push_back(mk(2, "b2b_b14",   0, 16'h0000, 1, e(1, 0, 14, 0, 1, 0)));
        tbl.push_back(mk(2, "b2b_idle",  0, 16'h0000, 1, idle));

        // Reset: in_valid asserted throughout must not be taken
        set_in(0, 1, 16'h00FF, 1);
        b_iv = 1'b1; b_d = 8'hFF;
        c_iv = 1'b1; c_d = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        check(0, "rst_a", idle);
        check(1, "rst_b", idle);
        check(2, "rst_c", idle);
        @(negedge clk);
        set_in(0, 0, 16'h0000, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].dut, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check(tbl[i].dut, tbl[i].name, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Test 5: async reset in the middle of a 16-bit scan
        set_in(2, 1, 16'h8001, 1);
        check(2, "ar_accept", idle);
        @(posedge clk); #1;
        set_in(2, 0, 16'h0000, 1);
        check(2, "ar_b15", e(1, 0, 15, 0, 0, 0));
        @(posedge clk); #1;
        check(2, "ar_b0", e(1, 0, 0, 1, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check(2, "ar_async", idle);
        set_in(2, 1, 16'h0040, 1);
        @(posedge clk); #1;
        check(2, "ar_held", idle);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_in(2, 0, 16'h0000, 1);
        check(2, "ar_x40", e(1, 0, 6, 0, 1, 0));
        @(posedge clk); #1;
        check(2, "ar_idle", idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pe_hi_scan
`default_nettype wire
